param_data_memory: RTL

Byte-addressable, little-endian data memory for the MEM stage, generalised over data width, depth, access size and read latency. It serves one request per cycle over a valid/ready handshake and returns responses through a fixed-latency pipeline. Loads can be sign- or zero-extended, and misaligned or out-of-range accesses are flagged. After every reset, an init state machine refills the whole array with a known byte.

---
 rtl/param_data_memory.sv | 128 ++++++++++++
 1 files changed

// File: rtl/param_data_memory.sv
// Byte-addressable little-endian data memory with a fixed-latency response pipe.
// An init FSM refills the array with INIT_BYTE after every reset before requests are accepted.
module param_data_memory #(
   parameter int         DATA_W      = 64,
   parameter int         DEPTH_BYTES = 512,
   parameter int         READ_LAT    = 1,
   parameter logic [7:0] INIT_BYTE   = 8'h01,
   parameter int         ADDR_W      = $clog2(DEPTH_BYTES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int BYTES = DATA_W / 8;
   localparam int WORDS = DEPTH_BYTES / BYTES;
   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int EXT_W = ADDR_W + 4;

   typedef enum logic {INIT, READY} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [7:0]        mem [DEPTH_BYTES];

   logic [3:0]        nbytes;
   logic [EXT_W-1:0]  ext_end;
   logic              misalign, oor, too_wide, err, acc;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] raw, mask, ld_data;
   logic              sbit;

   logic [READ_LAT-1:0]             vld_pipe, err_pipe;
   logic [READ_LAT-1:0][DATA_W-1:0] dat_pipe;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_ready = 1'b0;
      case (state)
         INIT: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_W'(WORDS - 1)) state_nxt = READY;
         end
         READY: req_ready = 1'b1;
         default: state_nxt = INIT;
      endcase
   end

   // Range check is done in a wider domain so addr + size cannot wrap back into range.
   always_comb begin
      nbytes   = 4'd1 << req_size;
      misalign = |(req_addr & ADDR_W'(nbytes - 4'd1));
      ext_end  = EXT_W'(req_addr) + EXT_W'(nbytes);
      oor      = ext_end > EXT_W'(DEPTH_BYTES);
      too_wide = (req_size == 2'd3) && (BYTES < 8);
      err      = misalign | oor | too_wide;
      acc      = req_valid & req_ready & ~rst;
   end

   // sbit ends up holding the top bit of the most significant loaded byte.
   always_comb begin
      raw  = '0;
      mask = '0;
      sbit = 1'b0;
      idx  = '0;
      for (int k = 0; k < BYTES; k++) begin
         idx = req_addr + ADDR_W'(k);
         if (k < int'(nbytes)) begin
            raw[8*k +: 8]  = mem[idx];
            mask[8*k +: 8] = 8'hFF;
            sbit           = mem[idx][7];
         end
      end
      ld_data = raw | ((req_signed && sbit) ? ~mask : '0);
   end

   // Array contents survive rst; the init sweep is what refills them.
   always_ff @(posedge clk) begin
      if (!rst && state == INIT) begin
         for (int k = 0; k < BYTES; k++)
            mem[ADDR_W'(int'(cnt) * BYTES + k)] <= INIT_BYTE;
      end else if (acc && req_write && !err) begin
         for (int k = 0; k < BYTES; k++)
            if (k < int'(nbytes)) mem[req_addr + ADDR_W'(k)] <= req_wdata[8*k +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         dat_pipe <= '0;
      end else begin
         vld_pipe[0] <= acc;
         err_pipe[0] <= acc & err;
         dat_pipe[0] <= (acc && !req_write && !err) ? ld_data : '0;
         for (int s = 1; s < READ_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            err_pipe[s] <= err_pipe[s-1];
            dat_pipe[s] <= dat_pipe[s-1];
         end
      end
   end

   assign rsp_valid = vld_pipe[READ_LAT-1];
   assign rsp_err   = err_pipe[READ_LAT-1];
   assign rsp_rdata = dat_pipe[READ_LAT-1];

endmodule
